// File: rtl/mult_pool_alloc_pkg.sv
// Shared constants and types for the convolution multiplier-pool slice.
package conv_pkg;
  localparam int unsigned NMULT = 64;
  localparam int unsigned MIDX  = 6;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNTW  = 7;
  localparam int unsigned RIDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, ALLOC} alloc_state_e;
  typedef logic [RIDW-1:0] req_id_t;
endpackage

// File: rtl/mult_pool_alloc_if.sv
// Request / grant / release bundle between conv controllers and the pool allocator.
interface mult_pool_alloc_if #(
  parameter int unsigned NMULT = conv_pkg::NMULT,
  parameter int unsigned MIDX  = conv_pkg::MIDX,
  parameter int unsigned NREQ  = conv_pkg::NREQ,
  parameter int unsigned CNTW  = conv_pkg::CNTW
);
  localparam int unsigned RIDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][CNTW-1:0] req_count;
  logic [NREQ-1:0]           req_ready;
  logic                      req_err;
  logic                      gnt_valid;
  logic                      gnt_ready;
  logic [RIDW-1:0]           gnt_req_id;
  logic [MIDX-1:0]           gnt_idx;
  logic                      gnt_last;
  logic                      rel_valid;
  logic [MIDX-1:0]           rel_idx;
  logic                      rel_err;
  logic [NMULT-1:0]          busy_map;
  logic [MIDX:0]             free_cnt;

  modport master (
    output req_valid, req_count, gnt_ready, rel_valid, rel_idx,
    input  req_ready, req_err, gnt_valid, gnt_req_id, gnt_idx, gnt_last,
           rel_err, busy_map, free_cnt
  );

  modport slave (
    input  req_valid, req_count, gnt_ready, rel_valid, rel_idx,
    output req_ready, req_err, gnt_valid, gnt_req_id, gnt_idx, gnt_last,
           rel_err, busy_map, free_cnt
  );
endinterface

// File: rtl/mult_pool_alloc_free_pe.sv
// Lowest-zero priority encoder over the multiplier occupancy map.
module mult_free_pe #(
  parameter int unsigned NMULT = conv_pkg::NMULT,
  parameter int unsigned MIDX  = conv_pkg::MIDX
) (
  input  logic [NMULT-1:0] map,
  output logic [MIDX-1:0]  idx,
  output logic             found
);
  import conv_pkg::*;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NMULT; i++) begin
      if (!found && !map[i]) begin
        found = 1'b1;
        idx   = MIDX'(i);
      end
    end
  end
endmodule

// File: rtl/mult_pool_alloc.sv
// Multiplier pool allocator: round-robin request acceptance, per-index grant
// stream, release port, and registered occupancy map / free count.
module mult_pool_alloc #(
  parameter int unsigned NMULT = conv_pkg::NMULT,
  parameter int unsigned MIDX  = conv_pkg::MIDX,
  parameter int unsigned NREQ  = conv_pkg::NREQ,
  parameter int unsigned CNTW  = conv_pkg::CNTW
) (
  input  logic             clk,
  input  logic             rstn,
  mult_pool_alloc_if.slave bus
);
  import conv_pkg::*;

  localparam int unsigned RIDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [MIDX:0] FULL_CNT = (MIDX+1)'(NMULT);

  alloc_state_e     state;
  logic [NMULT-1:0] busy_map;
  logic [MIDX:0]    free_cnt;
  logic [RIDW-1:0]  rr_ptr;
  logic [RIDW-1:0]  gnt_req_id;
  logic [MIDX-1:0]  gnt_idx;
  logic [CNTW-1:0]  remaining;

  logic [NREQ-1:0]  bad_cnt;
  logic [NREQ-1:0]  elig;
  logic             win_found;
  logic [RIDW-1:0]  win_id;
  logic             accept;
  logic             hs;
  logic             rel_hit;
  logic [NMULT-1:0] map_nxt;
  logic [MIDX:0]    busy_nxt_cnt;
  logic [MIDX:0]    free_nxt;
  logic [MIDX-1:0]  pe_idx;
  logic             pe_found;

  // Invalid counts are always eligible so they get flushed with req_err.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      bad_cnt[i] = (bus.req_count[i] == '0) || (32'(bus.req_count[i]) > NMULT);
      elig[i]    = bus.req_valid[i] &&
                   (bad_cnt[i] || (32'(bus.req_count[i]) <= 32'(free_cnt)));
    end
  end

  always_comb begin
    int unsigned j;
    j         = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_found && elig[j]) begin
        win_found = 1'b1;
        win_id    = RIDW'(j);
      end
    end
  end

  assign accept = (state == IDLE) && win_found;
  assign hs     = (state == ALLOC) && bus.gnt_ready;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[win_id] = 1'b1;
  end

  assign bus.req_err = accept && bad_cnt[win_id];

  always_comb begin
    rel_hit = 1'b0;
    if (bus.rel_valid && (32'(bus.rel_idx) < NMULT))
      rel_hit = busy_map[bus.rel_idx];
  end

  assign bus.rel_err = bus.rel_valid && !rel_hit;

  // A release and a grant handshake never target the same bit, so both apply.
  always_comb begin
    map_nxt = busy_map;
    if (rel_hit) map_nxt[bus.rel_idx] = 1'b0;
    if (hs)      map_nxt[gnt_idx]     = 1'b1;
  end

  always_comb begin
    busy_nxt_cnt = '0;
    for (int unsigned i = 0; i < NMULT; i++)
      busy_nxt_cnt = busy_nxt_cnt + (MIDX+1)'(map_nxt[i]);
  end

  assign free_nxt = FULL_CNT - busy_nxt_cnt;

  // Searching the post-update map lets a same-cycle release win the next grant.
  mult_free_pe #(
    .NMULT (NMULT),
    .MIDX  (MIDX)
  ) u_free_pe (
    .map   (map_nxt),
    .idx   (pe_idx),
    .found (pe_found)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      busy_map   <= '0;
      free_cnt   <= FULL_CNT;
      rr_ptr     <= '0;
      gnt_req_id <= '0;
      gnt_idx    <= '0;
      remaining  <= '0;
    end else begin
      busy_map <= map_nxt;
      free_cnt <= free_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= (32'(win_id) == NREQ - 1) ? '0 : RIDW'(win_id + 1'b1);
            if (!bad_cnt[win_id]) begin
              state      <= ALLOC;
              gnt_req_id <= win_id;
              remaining  <= bus.req_count[win_id];
              if (pe_found) gnt_idx <= pe_idx;
            end
          end
        end
        ALLOC: begin
          if (hs) begin
            remaining <= remaining - 1'b1;
            if (pe_found) gnt_idx <= pe_idx;
            if (remaining == CNTW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_valid  = (state == ALLOC);
  assign bus.gnt_req_id = gnt_req_id;
  assign bus.gnt_idx    = gnt_idx;
  assign bus.gnt_last   = (state == ALLOC) && (remaining == CNTW'(1));
  assign bus.busy_map   = busy_map;
  assign bus.free_cnt   = free_cnt;
endmodule

// File: tb/tb_mult_pool_alloc.sv
// Scoreboard bench for mult_pool_alloc: directed requests/releases push expected
// acceptances and grants; a negedge monitor pops and compares.
module tb_mult_pool_alloc;
  logic clk;
  logic rstn;

  mult_pool_alloc_if bus ();

  mult_pool_alloc dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [5:0] idx;
    logic       last;
  } gnt_t;

  typedef struct packed {
    logic [3:0] ready;
    logic       err;
  } acc_t;

  gnt_t gq[$];
  acc_t aq[$];
  int   rel_exp;
  int   n_tests;
  int   n_fail;
  logic [3:0] ready_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    gnt_t e;
    acc_t a;
    ready_seen = bus.req_ready;
    if (rstn) begin
      if (bus.gnt_valid && bus.gnt_ready) begin
        if (gq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL gnt_unexpected: got id %0d idx %0d, no grant expected",
                   bus.gnt_req_id, bus.gnt_idx);
        end else begin
          e = gq.pop_front();
          chk("gnt_req_id", 64'(bus.gnt_req_id), 64'(e.id));
          chk("gnt_idx",    64'(bus.gnt_idx),    64'(e.idx));
          chk("gnt_last",   64'(bus.gnt_last),   64'(e.last));
        end
      end
      if ((|bus.req_ready) || bus.req_err) begin
        if (aq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL acc_unexpected: got ready 0x%0h err %0b, no acceptance expected",
                   bus.req_ready, bus.req_err);
        end else begin
          a = aq.pop_front();
          chk("req_ready", 64'(bus.req_ready), 64'(a.ready));
          chk("req_err",   64'(bus.req_err),   64'(a.err));
        end
      end
      if (bus.rel_err) begin
        n_tests++;
        if (rel_exp == 0) begin
          n_fail++;
          $display("FAIL rel_err_unexpected: got pulse for idx %0d, expected none", bus.rel_idx);
        end else begin
          rel_exp--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~ready_seen;
    bus.rel_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_count = '0;
    bus.gnt_ready = 1'b1;
    bus.rel_valid = 1'b0;
    bus.rel_idx   = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic request(input int id, input int cnt);
    bus.req_valid[id] = 1'b1;
    bus.req_count[id] = 7'(cnt);
  endtask

  task automatic release_idx(input int idx, input bit expect_err);
    bus.rel_valid = 1'b1;
    bus.rel_idx   = 6'(idx);
    if (expect_err) rel_exp++;
    tick();
  endtask

  task automatic push_acc(input int id, input bit err);
    acc_t a;
    a.ready = 4'b0001 << id;
    a.err   = err;
    aq.push_back(a);
  endtask

  task automatic push_gnt(input int id, input int idx, input bit last);
    gnt_t e;
    e.id   = 2'(id);
    e.idx  = 6'(idx);
    e.last = last;
    gq.push_back(e);
  endtask

  task automatic push_run(input int id, input int first, input int n);
    for (int k = 0; k < n; k++) push_gnt(id, first + k, k == n - 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while ((gq.size() != 0 || aq.size() != 0 || bus.gnt_valid || bus.req_valid != '0)
           && c < budget) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d grants / %0d acceptances outstanding after %0d cycles, expected 0",
               name, gq.size(), aq.size(), budget);
      gq.delete();
      aq.delete();
      bus.req_valid = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_map;
    n_tests = 0;
    n_fail  = 0;
    rel_exp = 0;
    reset_dut();

    chk("rst_busy_map",   bus.busy_map,          64'h0);
    chk("rst_free_cnt",   64'(bus.free_cnt),     64'd64);
    chk("rst_gnt_valid",  64'(bus.gnt_valid),    64'd0);
    chk("rst_gnt_last",   64'(bus.gnt_last),     64'd0);
    chk("rst_gnt_idx",    64'(bus.gnt_idx),      64'd0);
    chk("rst_gnt_req_id", 64'(bus.gnt_req_id),   64'd0);
    chk("rst_req_ready",  64'(bus.req_ready),    64'd0);
    chk("rst_req_err",    64'(bus.req_err),      64'd0);
    chk("rst_rel_err",    64'(bus.rel_err),      64'd0);

    // Single request of 3 from an empty pool.
    push_acc(0, 1'b0);
    push_run(0, 0, 3);
    request(0, 3);
    wait_idle("single", 20);
    chk("single_busy_map", bus.busy_map,      64'h7);
    chk("single_free_cnt", 64'(bus.free_cnt), 64'd61);
    for (int i = 0; i < 3; i++) release_idx(i, 1'b0);
    chk("clean_busy_map", bus.busy_map, 64'h0);

    // rr_ptr is 1 now: requester 2 beats requester 0.
    push_acc(2, 1'b0);
    push_run(2, 0, 2);
    push_acc(0, 1'b0);
    push_run(0, 2, 2);
    request(0, 2);
    request(2, 2);
    wait_idle("rr_ptr1", 30);
    chk("rr_ptr1_busy_map", bus.busy_map, 64'hF);

    // After reset rr_ptr is 0: requester 0 first.
    reset_dut();
    push_acc(0, 1'b0);
    push_run(0, 0, 2);
    push_acc(2, 1'b0);
    push_run(2, 2, 2);
    request(0, 2);
    request(2, 2);
    wait_idle("rr_ptr0", 30);
    chk("rr_ptr0_busy_map", bus.busy_map, 64'hF);

    // Fill to 62 busy, then a pending request of 4 waits for two releases.
    push_acc(1, 1'b0);
    push_run(1, 4, 58);
    request(1, 58);
    wait_idle("fill", 200);
    chk("fill_free_cnt", 64'(bus.free_cnt), 64'd2);
    chk("fill_busy_map", bus.busy_map,      64'h3FFF_FFFF_FFFF_FFFF);
    request(3, 4);
    repeat (3) tick();
    chk("pending_valid", 64'(bus.req_valid), 64'h8);
    release_idx(10, 1'b0);
    chk("rel10_free_cnt", 64'(bus.free_cnt), 64'd3);
    push_acc(3, 1'b0);
    push_gnt(3, 10, 1'b0);
    push_gnt(3, 20, 1'b0);
    push_gnt(3, 62, 1'b0);
    push_gnt(3, 63, 1'b1);
    release_idx(20, 1'b0);
    wait_idle("pending", 30);
    chk("full_busy_map", bus.busy_map,      64'hFFFF_FFFF_FFFF_FFFF);
    chk("full_free_cnt", 64'(bus.free_cnt), 64'd0);

    // Backpressure: grant held stable while index 5 is released underneath.
    release_idx(3, 1'b0);
    release_idx(8, 1'b0);
    bus.gnt_ready = 1'b0;
    push_acc(0, 1'b0);
    request(0, 2);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.rel_valid = 1'b1;
        bus.rel_idx   = 6'd5;
      end
      @(negedge clk);
      chk("hold_gnt_valid", 64'(bus.gnt_valid), 64'd1);
      chk("hold_gnt_idx",   64'(bus.gnt_idx),   64'd3);
      chk("hold_gnt_last",  64'(bus.gnt_last),  64'd0);
      tick();
    end
    push_gnt(0, 3, 1'b0);
    push_gnt(0, 5, 1'b1);
    bus.gnt_ready = 1'b1;
    wait_idle("hold", 20);
    exp_map = ~(64'h1 << 8);
    chk("hold_busy_map", bus.busy_map,      exp_map);
    chk("hold_free_cnt", 64'(bus.free_cnt), 64'd1);

    // Invalid counts are flushed with req_err; an oversize valid count just waits.
    push_acc(1, 1'b1);
    request(0, 5);
    request(1, 0);
    tick();
    @(negedge clk);
    chk("err0_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    tick();
    push_acc(2, 1'b1);
    request(2, 65);
    tick();
    @(negedge clk);
    chk("err65_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    chk("err65_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    bus.req_valid[0] = 1'b0;
    chk("err_busy_map", bus.busy_map, exp_map);

    // Releasing an already-free index flags rel_err and leaves the map alone.
    release_idx(7, 1'b0);
    exp_map = ~((64'h1 << 8) | (64'h1 << 7));
    chk("rel7_busy_map", bus.busy_map, exp_map);
    release_idx(7, 1'b1);
    chk("rel7_again_busy_map", bus.busy_map,      exp_map);
    chk("rel7_free_cnt",       64'(bus.free_cnt), 64'd2);

    // Reset in the middle of a 4-multiplier allocation.
    reset_dut();
    push_acc(0, 1'b0);
    push_gnt(0, 0, 1'b0);
    push_gnt(0, 1, 1'b0);
    request(0, 4);
    tick();
    tick();
    tick();
    chk("midrst_grants_seen", 64'(gq.size()), 64'd0);
    rstn = 1'b0;
    #1;
    chk("midrst_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    chk("midrst_busy_map",  bus.busy_map,       64'h0);
    chk("midrst_free_cnt",  64'(bus.free_cnt),  64'd64);
    chk("midrst_gnt_last",  64'(bus.gnt_last),  64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) tick();
    chk("postrst_gnt_valid", 64'(bus.gnt_valid), 64'd0);
    chk("postrst_free_cnt",  64'(bus.free_cnt),  64'd64);

    chk("final_acc_pending", 64'(aq.size()), 64'd0);
    chk("final_gnt_pending", 64'(gq.size()), 64'd0);
    chk("final_rel_pending", 64'(rel_exp),   64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
